// File: rtl/min_scan_ctrl.sv
// Burst minimum sequencer: one time-shared registered min-compare stage.
// Optional MIN_IDX_EN adds the run_idx register and the min_idx port.
module min_scan_ctrl #(
    parameter int DW    = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [DW-1:0]    min_out
`ifdef MIN_IDX_EN
    ,
    output logic [LEN_W-1:0] min_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    run_min;
    logic [DW-1:0]    new_min;
    logic             accept;
    logic             last;
    logic             lower;

`ifdef MIN_IDX_EN
    logic [LEN_W-1:0] run_idx;
    logic [LEN_W-1:0] new_idx;
`endif

    assign in_ready = (state == SCAN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = in_ready && in_valid;
    assign last     = accept && (cnt == len_q - LEN_W'(1));

    // Post-compare value; strict less-than keeps the earliest tie
    always_comb begin
        lower   = (in_data < run_min);
        new_min = lower ? in_data : run_min;
`ifdef MIN_IDX_EN
        new_idx = lower ? cnt : run_idx;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : SCAN;
            end
            SCAN: begin
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Running minimum, beat counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            cnt     <= '0;
            run_min <= '1;
            min_out <= '0;
            empty   <= 1'b0;
`ifdef MIN_IDX_EN
            run_idx <= '0;
            min_idx <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
                len_q   <= len;
                cnt     <= '0;
                run_min <= '1;
`ifdef MIN_IDX_EN
                run_idx <= '0;
`endif
                if (len == '0) begin
                    min_out <= '1;
                    empty   <= 1'b1;
`ifdef MIN_IDX_EN
                    min_idx <= '0;
`endif
                end
            end
            if (accept) begin
                cnt     <= cnt + LEN_W'(1);
                run_min <= new_min;
`ifdef MIN_IDX_EN
                run_idx <= new_idx;
`endif
                if (last) begin
                    min_out <= new_min;
                    empty   <= 1'b0;
`ifdef MIN_IDX_EN
                    min_idx <= new_idx;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_min_scan_ctrl.sv
// Randomized bench for min_scan_ctrl against a list-based minimum model.
// Covers reset, stalls, ties, empty bursts, ignored starts and aborts.
module tb_min_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       empty;
    logic [7:0] min_out;
    logic [3:0] min_idx;

    int n_vec;
    int n_err;

    logic [7:0] bq[$];
    logic [7:0] exp_min;
    logic [3:0] exp_idx;
    logic       exp_empty;

    min_scan_ctrl #(.DW(8), .LEN_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .empty    (empty),
        .min_out  (min_out)
`ifdef MIN_IDX_EN
        ,
        .min_idx  (min_idx)
`endif
    );

`ifndef MIN_IDX_EN
    assign min_idx = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_min"}, min_out, exp_min);
        chk({tag, "_empty"}, empty, exp_empty);
`ifdef MIN_IDX_EN
        chk({tag, "_idx"}, min_idx, exp_idx);
`endif
    endtask

    // Model: minimum of the beat list, first index where it occurs
    task automatic model_burst();
        logic [7:0] m;
        int         mi;
        if (bq.size() == 0) begin
            exp_min   = 8'hFF;
            exp_idx   = 4'd0;
            exp_empty = 1'b1;
        end else begin
            m  = bq[0];
            mi = 0;
            foreach (bq[i]) if (bq[i] < m) begin
                m  = bq[i];
                mi = i;
            end
            exp_min   = m;
            exp_idx   = 4'(mi);
            exp_empty = 1'b0;
        end
    endtask

    task automatic do_burst(input int gap_max, input bit poke);
        int n;
        int g;
        n        = bq.size();
        start    = 1'b1;
        len      = 4'(n);
        step();
        start    = 1'b0;
        chk("busy_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                if (poke) begin
                    start = 1'b1;
                    len   = 4'($urandom);
                end
                step();
                chk("stall_ready", in_ready, 1);
                chk("stall_done", done, 0);
                check_result("stall_held");
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = bq[i];
            chk("beat_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            if (i < n - 1) chk("early_done", done, 0);
        end
        model_burst();
        in_valid = 1'b1;
        in_data  = 8'h00;
        chk("done_pulse", done, 1);
        chk("done_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        check_result("done");
        step();
        in_valid = 1'b0;
        chk("done_clr", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 0);
        check_result("idle_held");
    endtask

    task automatic abort_burst(input int n, input int k);
        start = 1'b1;
        len   = 4'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("abort_done", done, 0);
        step();
        rst       = 1'b0;
        exp_min   = 8'h00;
        exp_idx   = 4'd0;
        exp_empty = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_done2", done, 0);
        check_result("abort");
        step();
        chk("abort_quiet", done, 0);
    endtask

    function automatic logic [7:0] rnd_data();
        if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        len      = 4'd0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) step();
        rst       = 1'b0;
        exp_min   = 8'h00;
        exp_idx   = 4'd0;
        exp_empty = 1'b0;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_result("rst");

        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        chk("idle_novalid", in_ready, 0);
        in_valid = 1'b0;

        bq = '{8'd9, 8'd3, 8'd7, 8'd5};
        do_burst(0, 1'b0);

        bq = '{8'd8, 8'd2, 8'd2};
        do_burst(3, 1'b0);

        bq = {};
        do_burst(0, 1'b0);

        bq = {};
        for (int i = 0; i < 14; i++) bq.push_back(8'hFF);
        bq.push_back(8'h00);
        do_burst(2, 1'b1);

        abort_burst(5, 2);
        bq = '{8'd6};
        do_burst(0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                abort_burst($urandom_range(2, 15), $urandom_range(0, 1));
            end else begin
                bq = {};
                repeat ($urandom_range(0, 15)) bq.push_back(rnd_data());
                do_burst($urandom_range(0, 2), 1'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b1;
                    step();
                    chk("gap_ready", in_ready, 0);
                    in_valid = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
